communication_control: RTL and testbench
========================================

COMMUNICATION_CONTROL -- requirements
Module: communication_control

Parameters
REQ-001 The block SHALL have parameter ULTRA_TIMEOUT, default 5_000_000, the maximum number of cycles spent in WAIT_ULTRA (50 ms at 100 MHz).
REQ-002 The block SHALL have parameter RX_TIMEOUT, default 1_000_000, the maximum number of cycles spent in WAIT_RX.

Interface
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start_communication, input, 1 bit: request to start one measure/transmit/receive cycle.
REQ-006 The block SHALL have port ultrasonic_valid, input, 1 bit: ultrasonic measurement complete (level).
REQ-007 The block SHALL have port tx_ready, input, 1 bit: transmitter accepts data.
REQ-008 The block SHALL have port rx_valid, input, 1 bit: receiver holds valid data.
REQ-009 The block SHALL have port start_ultra, output, 1 bit: one-cycle trigger to the ultrasonic sensor.
REQ-010 The block SHALL have port tx_valid, output, 1 bit: data offered to the transmitter.
REQ-011 The block SHALL have port rx_ready, output, 1 bit: block ready to accept received data.
REQ-012 The block SHALL have port data_valid, output, 1 bit: one-cycle pulse signalling a completed exchange.

Function
REQ-013 The block SHALL be a Moore FSM with states IDLE, TRIGGER, WAIT_ULTRA, TX, WAIT_RX and DONE; all outputs SHALL be decoded from the registered state only.
REQ-014 In IDLE all outputs SHALL be 0; when start_communication=1 at a clock edge, the next state SHALL be TRIGGER; otherwise the FSM SHALL stay in IDLE.
REQ-015 In TRIGGER, start_ultra SHALL be 1 for exactly one cycle, and the next state SHALL unconditionally be WAIT_ULTRA.
REQ-016 In WAIT_ULTRA all outputs SHALL be 0; ultrasonic_valid=1 SHALL move the FSM to TX, and ultrasonic_valid=0 SHALL keep it in WAIT_ULTRA.
REQ-017 In TX, tx_valid SHALL be 1; a transfer occurs when tx_valid and tx_ready are both 1 on the same edge, after which the next state SHALL be WAIT_RX; TX has no timeout and tx_valid SHALL stay 1 until tx_ready.
REQ-018 In WAIT_RX, rx_ready SHALL be 1; rx_valid=1 SHALL move the FSM to DONE.
REQ-019 In DONE, data_valid SHALL be 1 for exactly one cycle, and the next state SHALL unconditionally be IDLE.
REQ-020 A 32-bit cycle counter SHALL clear on every state change and increment each cycle while in WAIT_ULTRA or WAIT_RX.
REQ-021 When the counter reaches ULTRA_TIMEOUT-1 in WAIT_ULTRA, or RX_TIMEOUT-1 in WAIT_RX, without the awaited input, the FSM SHALL return to IDLE without asserting data_valid.
REQ-022 If the awaited input and the timeout occur on the same edge, the input SHALL win.
REQ-023 start_communication SHALL be ignored in every state except IDLE; no request is queued.
REQ-024 Each output SHALL be 1 only in its own state, so that at most one output is high in any cycle.
REQ-025 ultrasonic_valid held high after TX SHALL have no effect.
REQ-026 In WAIT_ULTRA and WAIT_RX, single-cycle pulses on tx_ready or rx_valid SHALL be acted on only in the matching state; pulses arriving in the other state SHALL be dropped.

Reset
REQ-027 When reset=1 at a clock edge, the FSM SHALL go to IDLE, the counter SHALL clear, and all outputs SHALL be 0 from the next cycle, from any state, including mid-exchange.
REQ-028 Reset SHALL take priority over all other inputs.

Verification
REQ-029 Reset for 1 cycle, start_communication pulsed for 1 cycle -> start_ultra=1 for exactly 1 cycle, one cycle after the request edge.
REQ-030 Full exchange: ultrasonic_valid raised 3 ms after the trigger -> tx_valid=1 until the 1-cycle tx_ready pulse 200 ns later; then rx_ready=1 until the rx_valid pulse 10 µs later; then data_valid=1 for 1 cycle; then IDLE with all outputs 0.
REQ-031 tx_ready held 0 for 10 µs in TX -> tx_valid stays 1 and there is no timeout.
REQ-032 With ULTRA_TIMEOUT=100 and ultrasonic_valid never asserted -> return to IDLE after 100 WAIT_ULTRA cycles, with no tx_valid and no data_valid.
REQ-033 start_communication re-pulsed while in WAIT_RX -> no second start_ultra; the exchange completes normally.
REQ-034 reset asserted in TX -> tx_valid=0 on the next cycle and the FSM is in IDLE; a fresh start_communication then restarts the sequence.

Source files
------------

// File: rtl/communication_control.sv
// Sequencer for one measure/transmit/receive exchange: trigger the ultrasonic
// sensor, hand the result to the transmitter, await the reply, then pulse data_valid.
module communication_control #(
    parameter int unsigned ULTRA_TIMEOUT = 32'd5_000_000,
    parameter int unsigned RX_TIMEOUT    = 32'd1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic start_communication,
    input  logic ultrasonic_valid,
    input  logic tx_ready,
    input  logic rx_valid,
    output logic start_ultra,
    output logic tx_valid,
    output logic rx_ready,
    output logic data_valid
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_TRIGGER    = 3'd1,
        S_WAIT_ULTRA = 3'd2,
        S_TX         = 3'd3,
        S_WAIT_RX    = 3'd4,
        S_DONE       = 3'd5
    } state_t;

    localparam logic [31:0] ULTRA_LAST = 32'(ULTRA_TIMEOUT - 32'd1);
    localparam logic [31:0] RX_LAST    = 32'(RX_TIMEOUT - 32'd1);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        start_ultra_q, start_ultra_d;
    logic        tx_valid_q, tx_valid_d;
    logic        rx_ready_q, rx_ready_d;
    logic        data_valid_q, data_valid_d;

    // Next-state logic; the awaited input is tested before the timeout so it wins a tie.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_communication) state_d = S_TRIGGER;
                else                     state_d = S_IDLE;
            end
            S_TRIGGER: state_d = S_WAIT_ULTRA;
            S_WAIT_ULTRA: begin
                if (ultrasonic_valid)         state_d = S_TX;
                else if (cnt_q == ULTRA_LAST) state_d = S_IDLE;
                else                          state_d = S_WAIT_ULTRA;
            end
            S_TX: begin
                if (tx_ready) state_d = S_WAIT_RX;
                else          state_d = S_TX;
            end
            S_WAIT_RX: begin
                if (rx_valid)              state_d = S_DONE;
                else if (cnt_q == RX_LAST) state_d = S_IDLE;
                else                       state_d = S_WAIT_RX;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Wait counter: restarts on any state change, runs only in the two wait states.
    always_comb begin
        cnt_d = 32'd0;
        if (state_d != state_q) begin
            cnt_d = 32'd0;
        end else if ((state_q == S_WAIT_ULTRA) || (state_q == S_WAIT_RX)) begin
            cnt_d = cnt_q + 32'd1;
        end else begin
            cnt_d = 32'd0;
        end
    end

    // Outputs decoded from the upcoming state so the flops mirror the registered state.
    always_comb begin
        start_ultra_d = 1'b0;
        tx_valid_d    = 1'b0;
        rx_ready_d    = 1'b0;
        data_valid_d  = 1'b0;
        case (state_d)
            S_TRIGGER: start_ultra_d = 1'b1;
            S_TX:      tx_valid_d    = 1'b1;
            S_WAIT_RX: rx_ready_d    = 1'b1;
            S_DONE:    data_valid_d  = 1'b1;
            default: begin
                start_ultra_d = 1'b0;
                tx_valid_d    = 1'b0;
                rx_ready_d    = 1'b0;
                data_valid_d  = 1'b0;
            end
        endcase
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= 32'd0;
            start_ultra_q <= 1'b0;
            tx_valid_q    <= 1'b0;
            rx_ready_q    <= 1'b0;
            data_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            start_ultra_q <= start_ultra_d;
            tx_valid_q    <= tx_valid_d;
            rx_ready_q    <= rx_ready_d;
            data_valid_q  <= data_valid_d;
        end
    end

    assign start_ultra = start_ultra_q;
    assign tx_valid    = tx_valid_q;
    assign rx_ready    = rx_ready_q;
    assign data_valid  = data_valid_q;

endmodule

// File: tb/tb_communication_control.sv
// Bench for communication_control: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a phase-level model.
module tb_communication_control;

    localparam int UT = 100;
    localparam int RT = 1100;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start_communication = 1'b0;
    logic ultrasonic_valid = 1'b0;
    logic tx_ready = 1'b0;
    logic rx_valid = 1'b0;
    logic start_ultra, tx_valid, rx_ready, data_valid;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    communication_control #(.ULTRA_TIMEOUT(UT), .RX_TIMEOUT(RT)) dut (
        .clk                 (clk),
        .reset               (reset),
        .start_communication (start_communication),
        .ultrasonic_valid    (ultrasonic_valid),
        .tx_ready            (tx_ready),
        .rx_valid            (rx_valid),
        .start_ultra         (start_ultra),
        .tx_valid            (tx_valid),
        .rx_ready            (rx_ready),
        .data_valid          (data_valid)
    );

    always #5 clk = ~clk;

    // Model: which phase of the exchange we are in and how long we have been there.
    localparam int P_IDLE = 0, P_TRIG = 1, P_WU = 2, P_TX = 3, P_WR = 4, P_DONE = 5;
    int ph  = P_IDLE;
    int age = 0;
    logic [3:0] phase_out [6] = '{4'b0000, 4'b1000, 4'b0000, 4'b0100, 4'b0010, 4'b0001};

    always @(posedge clk) begin
        int nxt;
        if (reset) begin
            ph  = P_IDLE;
            age = 0;
        end else begin
            nxt = ph;
            if (ph == P_IDLE && start_communication)                nxt = P_TRIG;
            else if (ph == P_TRIG)                                  nxt = P_WU;
            else if (ph == P_WU && ultrasonic_valid)                nxt = P_TX;
            else if (ph == P_WU && age + 1 >= UT)                   nxt = P_IDLE;
            else if (ph == P_TX && tx_ready)                        nxt = P_WR;
            else if (ph == P_WR && rx_valid)                        nxt = P_DONE;
            else if (ph == P_WR && age + 1 >= RT)                   nxt = P_IDLE;
            else if (ph == P_DONE)                                  nxt = P_IDLE;
            age = (nxt == ph) ? age + 1 : 0;
            ph  = nxt;
        end
    end

    // Every-cycle comparison of the four outputs against the model phase.
    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            n_cmp++;
            if ({start_ultra, tx_valid, rx_ready, data_valid} !== phase_out[ph]) begin
                n_bad++;
                $display("FAIL cycle_cmp t=%0t phase=%0d got=%b want=%b", $time, ph,
                         {start_ultra, tx_valid, rx_ready, data_valid}, phase_out[ph]);
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%b want=%b", name, got, want);
        end
    endtask

    task automatic check_ph(input string name, input int want);
        n_cmp++;
        if (ph != want) begin
            n_bad++;
            $display("FAIL %s model_phase=%0d want=%0d", name, ph, want);
        end
    endtask

    function automatic logic [3:0] outs();
        return {start_ultra, tx_valid, rx_ready, data_valid};
    endfunction

    // Pulse start and land in the first WAIT_ULTRA cycle.
    task automatic kick();
        start_communication = 1'b1;
        tick();
        start_communication = 1'b0;
        check("trigger_pulse", outs(), 4'b1000);
        tick();
        check("trigger_one_cycle", outs(), 4'b0000);
    endtask

    initial begin
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_en = 1'b1;
        check("reset_state", outs(), 4'b0000);
        tick(3);
        check("idle_quiet", outs(), 4'b0000);

        // Full exchange with a long TX stall and a start re-pulse during WAIT_RX.
        kick();
        tick(29);
        ultrasonic_valid = 1'b1;
        tick();
        ultrasonic_valid = 1'b0;
        check("enter_tx", outs(), 4'b0100);
        tick(1000);
        check("tx_no_timeout", outs(), 4'b0100);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("enter_wait_rx", outs(), 4'b0010);
        start_communication = 1'b1;
        tick();
        start_communication = 1'b0;
        check("start_ignored_in_rx", outs(), 4'b0010);
        tick(998);
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        check("data_valid_pulse", outs(), 4'b0001);
        check_ph("model_done", P_DONE);
        tick();
        check("back_to_idle", outs(), 4'b0000);

        // Ultrasonic timeout: after UT cycles a late ultrasonic_valid is ignored.
        kick();
        tick(UT - 1);
        check("wu_last_cycle", outs(), 4'b0000);
        tick();
        check_ph("model_wu_timeout", P_IDLE);
        ultrasonic_valid = 1'b1;
        tick();
        ultrasonic_valid = 1'b0;
        check("wu_timeout_no_tx", outs(), 4'b0000);
        tick(2);

        // Input beats timeout on the last WAIT_ULTRA cycle.
        kick();
        tick(UT - 1);
        ultrasonic_valid = 1'b1;
        tick();
        ultrasonic_valid = 1'b0;
        check("tie_input_wins", outs(), 4'b0100);

        // Reset mid-TX, then a fresh exchange restarts.
        tick(5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_in_tx", outs(), 4'b0000);
        kick();
        ultrasonic_valid = 1'b1;
        tick();
        ultrasonic_valid = 1'b0;
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("restart_to_rx", outs(), 4'b0010);

        // Receive timeout after RT cycles in WAIT_RX.
        tick(RT - 1);
        check("wr_last_cycle", outs(), 4'b0010);
        tick();
        check("wr_timeout", outs(), 4'b0000);
        check_ph("model_wr_timeout", P_IDLE);

        // Randomized traffic checked by the every-cycle compare.
        for (int i = 0; i < 4000; i++) begin
            start_communication = ($urandom_range(15) == 0);
            ultrasonic_valid    = ($urandom_range(7) == 0);
            tx_ready            = ($urandom_range(3) == 0);
            rx_valid            = ($urandom_range(7) == 0);
            reset               = ($urandom_range(199) == 0);
            tick();
        end
        start_communication = 1'b0;
        ultrasonic_valid    = 1'b0;
        tx_ready            = 1'b0;
        rx_valid            = 1'b0;
        reset               = 1'b1;
        tick();
        reset = 1'b0;
        check("final_idle", outs(), 4'b0000);
        tick(2);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
